// File: rtl/pin_debounce_counter_pkg.sv
// Shared types and default constants for the pin debounce counter.
package pin_debounce_counter_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 4096;
    localparam int unsigned CNT_W_DEFAULT           = 8;

    typedef enum logic [1:0] {
        StStableLow  = 2'd0,
        StWaitHigh   = 2'd1,
        StStableHigh = 2'd2,
        StWaitLow    = 2'd3
    } deb_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for bringing asynchronous pins into the clk domain.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pin_debounce_counter.sv
// Debounces a raw board pin, emits one-cycle rise/fall pulses and counts accepted presses.
module pin_debounce_counter
    import pin_debounce_counter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             pin_in,
    input  logic             clear,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] press_count
);

    localparam int unsigned TW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [TW-1:0] TimerMax = TW'(DEBOUNCE_CYCLES - 1);

    logic s;

    sync_2ff #(
        .WIDTH (1)
    ) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (pin_in),
        .q      (s)
    );

    deb_state_e       state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StStableLow;
            timer_q <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            count_q <= count_d;
        end
    end

    // A mismatching sample restarts the wait; N+1 consecutive new-level samples accept it.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        unique case (state_q)
            StStableLow: begin
                if (s) begin
                    state_d = StWaitHigh;
                    timer_d = '0;
                end
            end
            StWaitHigh: begin
                if (!s) begin
                    state_d = StStableLow;
                    timer_d = '0;
                end else if (timer_q == TimerMax) begin
                    state_d = StStableHigh;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StStableHigh: begin
                if (!s) begin
                    state_d = StWaitLow;
                    timer_d = '0;
                end
            end
            StWaitLow: begin
                if (s) begin
                    state_d = StStableHigh;
                    timer_d = '0;
                end else if (timer_q == TimerMax) begin
                    state_d = StStableLow;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = StStableLow;
                timer_d = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so level and the pulses change together.
    always_comb begin
        level_d = (state_d == StStableHigh) || (state_d == StWaitLow);
        rise_d  = (state_q == StWaitHigh) && (state_d == StStableHigh);
        fall_d  = (state_q == StWaitLow) && (state_d == StStableLow);
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (rise_d) begin
            count_d = count_q + 1'b1;
        end
    end

    assign level       = level_q;
    assign rise        = rise_q;
    assign fall        = fall_q;
    assign press_count = count_q;

endmodule

// File: tb/tb_pin_debounce_counter.sv
// Bench for pin_debounce_counter: run-length reference model plus directed and random stimulus.
module tb_pin_debounce_counter;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       pin_in = 1'b0;
    logic       clear = 1'b0;
    logic       level;
    logic       rise;
    logic       fall;
    logic [7:0] press_count;

    int n_cmp_a = 0;
    int n_err_a = 0;
    int n_cmp_b = 0;
    int n_err_b = 0;

    always #5 clk = ~clk;

    pin_debounce_counter #(
        .DEBOUNCE_CYCLES (N),
        .CNT_W           (8)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .pin_in      (pin_in),
        .clear       (clear),
        .level       (level),
        .rise        (rise),
        .fall        (fall),
        .press_count (press_count)
    );

    // Reference: s is pin_in delayed by two edges; the level flips once s has disagreed
    // with it on N+1 consecutive edges.
    logic       h1_m, h2_m;
    int         run_m;
    logic       lvl_m, rise_m, fall_m;
    logic [7:0] cnt_m;
    logic       m_diff, m_flip;

    always_comb begin
        m_diff = (h2_m != lvl_m);
        m_flip = m_diff && (run_m == N);
    end

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            h1_m   <= 1'b0;
            h2_m   <= 1'b0;
            run_m  <= 0;
            lvl_m  <= 1'b0;
            rise_m <= 1'b0;
            fall_m <= 1'b0;
            cnt_m  <= 8'd0;
        end else begin
            h1_m   <= pin_in;
            h2_m   <= h1_m;
            run_m  <= (m_diff && !m_flip) ? run_m + 1 : 0;
            lvl_m  <= m_flip ? !lvl_m : lvl_m;
            rise_m <= m_flip && !lvl_m;
            fall_m <= m_flip && lvl_m;
            cnt_m  <= clear ? 8'd0 : ((m_flip && !lvl_m) ? cnt_m + 8'd1 : cnt_m);
        end
    end

    always @(negedge clk) begin
        if (resetn) begin
            n_cmp_a <= n_cmp_a + 1;
            if ({level, rise, fall, press_count} !== {lvl_m, rise_m, fall_m, cnt_m}
                || (rise && fall)) begin
                n_err_a <= n_err_a + 1;
                $display("FAIL cycle_model t=%0t: got level=%b rise=%b fall=%b count=%0d, expected level=%b rise=%b fall=%b count=%0d",
                         $time, level, rise, fall, press_count, lvl_m, rise_m, fall_m, cnt_m);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp_b++;
        if (act !== exp) begin
            n_err_b++;
            $display("FAIL %s t=%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic seen;

        // Reset with pin already high, then debounce toward high after release.
        #2 resetn = 1'b0;
        pin_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_level", 32'(level), 0);
        check("reset_rise", 32'(rise), 0);
        check("reset_fall", 32'(fall), 0);
        check("reset_count", 32'(press_count), 0);
        @(negedge clk) resetn = 1'b1;
        repeat (6) tick();
        check("rel_high_edge6_level", 32'(level), 0);
        tick();
        check("rel_high_edge7_level", 32'(level), 1);
        check("rel_high_edge7_rise", 32'(rise), 1);
        check("rel_high_edge7_count", 32'(press_count), 1);
        tick();
        check("rel_high_edge8_rise", 32'(rise), 0);

        // Held high->low change.
        pin_in = 1'b0;
        repeat (6) tick();
        check("fall_edge6_level", 32'(level), 1);
        check("fall_edge6_fall", 32'(fall), 0);
        tick();
        check("fall_edge7_fall", 32'(fall), 1);
        check("fall_edge7_level", 32'(level), 0);
        check("fall_edge7_count", 32'(press_count), 1);
        tick();
        check("fall_edge8_fall", 32'(fall), 0);

        // Four-cycle glitch is rejected.
        pin_in = 1'b1;
        repeat (4) tick();
        pin_in = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            seen = seen | rise | level;
        end
        check("glitch_no_rise_or_level", 32'(seen), 0);
        check("glitch_count", 32'(press_count), 1);

        // Clear coincident with the accepted rise.
        pin_in = 1'b1;
        repeat (6) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_rise", 32'(rise), 1);
        check("clr_level", 32'(level), 1);
        check("clr_count", 32'(press_count), 0);
        tick();
        check("clr_rise_next", 32'(rise), 0);
        check("clr_count_next", 32'(press_count), 0);
        pin_in = 1'b0;
        repeat (10) tick();

        // 256 presses wrap the counter.
        for (int i = 1; i <= 256; i++) begin
            pin_in = 1'b1;
            repeat (10) tick();
            if (i == 1)   check("wrap_press1", 32'(press_count), 1);
            if (i == 255) check("wrap_press255", 32'(press_count), 255);
            if (i == 256) check("wrap_press256", 32'(press_count), 0);
            pin_in = 1'b0;
            repeat (10) tick();
        end

        // Random runs with occasional clears.
        for (int r = 0; r < 300; r++) begin
            int len;
            pin_in = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 12));
            for (int k = 0; k < len; k++) begin
                clear = ($urandom_range(0, 15) == 0);
                tick();
            end
        end
        clear = 1'b0;

        // Reset in the middle of a pending rise.
        pin_in = 1'b0;
        repeat (10) tick();
        pin_in = 1'b1;
        repeat (10) tick();
        pin_in = 1'b0;
        repeat (10) tick();
        pin_in = 1'b1;
        repeat (5) tick();
        #2 resetn = 1'b0;
        #1;
        check("midwait_rst_level", 32'(level), 0);
        check("midwait_rst_rise", 32'(rise), 0);
        check("midwait_rst_fall", 32'(fall), 0);
        check("midwait_rst_count", 32'(press_count), 0);
        pin_in = 1'b0;
        @(negedge clk) resetn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            seen = seen | rise | level;
        end
        check("midwait_no_rise_after", 32'(seen), 0);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp_a + n_cmp_b, n_err_a + n_err_b);
        $finish;
    end

endmodule
